// File: rtl/gray_code_pkg.sv
// Shared definitions for the Gray-code counter: default width and the
// binary/Gray conversion helpers used for constants and by other blocks.
package gray_code_pkg;

    // Default counter width in bits.
    localparam int DEFAULT_WIDTH = 4;

    // Widest counter the helpers below are sized for.
    localparam int MAX_WIDTH = 32;

    // Binary to reflected Gray code. Each Gray bit is the XOR of two
    // adjacent binary bits. The MSB is unchanged.
    function automatic logic [MAX_WIDTH-1:0] to_gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray code back to binary. Each binary bit is the XOR of all Gray
    // bits at or above its position, accumulated from the MSB down.
    function automatic logic [MAX_WIDTH-1:0] to_bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b = '0;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : gray_code_pkg

// File: rtl/gray_code_bin2gray.sv
// Purely combinational binary-to-Gray converter. It is kept in its own
// module so that the top level holds only registers and next-state logic.
module bin2gray
    import gray_code_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    // Each lower Gray bit is the XOR of two adjacent binary bits.
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_xor
        assign gray_o[gi] = bin_i[gi] ^ bin_i[gi+1];
    end

    // The MSB passes straight through.
    assign gray_o[WIDTH-1] = bin_i[WIDTH-1];

endmodule : bin2gray

// File: rtl/gray_code.sv
// Up/down Gray-code counter with synchronous load.
// The state is a binary count. Both the Gray output and the binary output
// are taken straight from flops, so they cannot glitch. The wrap flag is a
// registered pulse that lasts one cycle after each wrap-around step.
module gray_code
    import gray_code_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(to_gray(MAX_WIDTH'(RESET_VAL)));

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    // Next-state logic. Load has priority over counting, and counting has
    // priority over holding. A wrap is flagged when an up-count starts from
    // all ones, or when a down-count starts from zero.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up_dn) begin
                bin_d  = bin_q + ONE;
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = ~|bin_q;
            end
        end
    end

    // The Gray value is encoded from the next binary count so that it can be
    // registered on the same edge as the count itself.
    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    // Count and output registers. Reset forces them immediately to the reset
    // value, with no dependence on the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= RESET_BIN;
            gray_q <= RESET_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = gray_q;
    assign bin  = bin_q;
    assign wrap = wrap_q;

endmodule : gray_code

// File: tb/tb_gray_code.sv
// Randomised and directed bench for the 4-bit Gray-code counter. A modular
// arithmetic reference model predicts bin and wrap. The expected Gray code is
// derived from the model's count, and one scenario uses a literal sequence.
module tb_gray_code;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] out_w;
    logic [3:0] bin_w;
    logic       wrap_w;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_bin  = 0;
    bit m_wrap = 1'b0;

    logic [3:0] exp_seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    gray_code #(
        .WIDTH     (4),
        .RESET_VAL (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .out      (out_w),
        .bin      (bin_w),
        .wrap     (wrap_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all DUT outputs against the model state.
    task automatic check_model(input string tag);
        logic [3:0] mb;
        mb = 4'(m_bin);
        check({tag, ".bin"},  bin_w,  mb);
        check({tag, ".out"},  out_w,  mb ^ (mb >> 1));
        check({tag, ".wrap"}, wrap_w, m_wrap);
    endtask

    // One clock of stimulus. The model advances with plain modular arithmetic.
    // Outputs are sampled 1 ns after the rising edge.
    task automatic step(input bit e, input bit u, input bit l, input logic [3:0] lv,
                        input string tag);
        logic [3:0] prev_out;
        int         nxt;
        bit         wr;
        prev_out = out_w;
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = lv;
        @(posedge clk);
        #1;
        if (l) begin
            nxt = lv;
            wr  = 1'b0;
        end else if (e) begin
            nxt = m_bin + (u ? 1 : -1);
            wr  = (nxt < 0) || (nxt > 15);
            nxt = (nxt + 16) % 16;
        end else begin
            nxt = m_bin;
            wr  = 1'b0;
        end
        m_bin  = nxt;
        m_wrap = wr;
        check_model(tag);
        if (!l && e)
            check({tag, ".hamming"}, $countones(prev_out ^ out_w), 1);
        $display("%s en=%0b up=%0b load=%0b lv=%0d -> bin=%0d out=%b wrap=%0b",
                 tag, e, u, l, lv, bin_w, out_w, wrap_w);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;

        // Reset state with no clock edge seen yet
        #3;
        check_model("reset");

        // Release between edges. The very next edge must count.
        #9 rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b1, 1'b0, 4'd0, "upseq");
            check("upseq.table", out_w, exp_seq[k % 16]);
        end
        check("upseq.wrap_end", wrap_w, 1'b1);

        // Twenty down steps starting from zero
        for (int k = 0; k < 20; k++)
            step(1'b1, 1'b0, 1'b0, 4'd0, "down");

        // Load takes priority over enable on the same edge
        step(1'b1, 1'b0, 1'b1, 4'd9, "load9");
        check("load9.gray", out_w, 4'b1101);
        step(1'b1, 1'b1, 1'b0, 4'd0, "load9.up");
        check("load9.up.gray", out_w, 4'b1111);

        // Wrap up from 15, then hold. Wrap must drop and the count must stay.
        step(1'b0, 1'b1, 1'b1, 4'd15, "ld15");
        step(1'b1, 1'b1, 1'b0, 4'd0, "wrapup");
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, 1'b0, 4'd0, "hold");

        // Consecutive wraps: 15 <-> 0 alternating
        step(1'b1, 1'b0, 1'b0, 4'd0, "cw1");
        step(1'b1, 1'b1, 1'b0, 4'd0, "cw2");

        // Asynchronous reset in mid-cycle at count 7
        step(1'b0, 1'b1, 1'b1, 4'd6, "ld6");
        step(1'b1, 1'b1, 1'b0, 4'd0, "to7");
        #2 rst_n = 1'b0;
        #1;
        m_bin  = 0;
        m_wrap = 1'b0;
        check_model("midrst");
        en    = 1'b1;
        up_dn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_model("inrst");
        end
        #3 rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 4'd0, "post_rst");

        // Random traffic
        for (int k = 0; k < 1000; k++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
                 4'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_gray_code

// File: doc/gray_code.md
GRAY_CODE -- requirements
Module: gray_code

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter RESET_VAL, default 0, giving the binary count loaded at reset (must be < 2^WIDTH).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The module SHALL have port en, input, 1 bit, count enable.
REQ-006 The module SHALL have port up_dn, input, 1 bit, count direction (1 = up, 0 = down).
REQ-007 The module SHALL have port load, input, 1 bit, synchronous load strobe.
REQ-008 The module SHALL have port load_val, input, WIDTH bits, the binary value to load.
REQ-009 The module SHALL have port out, output, WIDTH bits, the registered Gray-code count.
REQ-010 The module SHALL have port bin, output, WIDTH bits, the registered binary equivalent of out.
REQ-011 The module SHALL have port wrap, output, 1 bit, a one-cycle pulse flagging a wrap-around step.

Function
REQ-012 The module SHALL hold state in a WIDTH-bit binary count register and register out = next_bin ^ (next_bin >> 1), so out is a flop output with no combinational glitches.
REQ-013 Priority per rising edge SHALL be: load > en > hold.
REQ-014 When load = 1, bin SHALL become load_val and out SHALL become gray(load_val) on that edge, with wrap = 0, regardless of en and up_dn.
REQ-015 When load = 0 and en = 1 with up_dn = 1, bin SHALL increment by 1 modulo 2^WIDTH.
REQ-016 When load = 0 and en = 1 with up_dn = 0, bin SHALL decrement by 1 modulo 2^WIDTH.
REQ-017 When load = 0 and en = 0, bin, out and wrap SHALL hold their values, except that wrap SHALL return to 0.
REQ-018 Latency SHALL be one cycle: out and bin reflect the new count in the cycle after the enabling edge.
REQ-019 Up-wrap SHALL take bin from 2^WIDTH-1 to 0, and down-wrap SHALL take bin from 0 to 2^WIDTH-1.
REQ-020 wrap SHALL be 1 for exactly the cycle following a wrapping step and 0 otherwise; consecutive wraps SHALL each produce their own pulse.
REQ-021 Every counting step, including wrap-around, SHALL change exactly one bit of out; a load may change any number of bits.
REQ-022 A change of up_dn SHALL take effect on the next enabled edge with no lost or duplicated count.
REQ-023 The module SHALL contain no combinational path from any input to out, bin or wrap.

Reset
REQ-024 When rst_n = 0, bin SHALL be RESET_VAL, out SHALL be gray(RESET_VAL) and wrap SHALL be 0, immediately and independent of clk.
REQ-025 Asserting rst_n mid-count SHALL abort the current count with no partial update.
REQ-026 The first counting edge SHALL be the first rising edge of clk after rst_n deasserts, with no extra delay cycle.

Structure
REQ-027 The project package SHALL hold the WIDTH default and the bin-to-Gray and Gray-to-binary conversion functions.
REQ-028 Binary-to-Gray conversion SHALL be isolated in one combinational sub-module, bin2gray, parameterised by WIDTH.
REQ-029 The top level SHALL contain only the count register, the next-state logic and the output registers.

Verification
REQ-030 Reset scenario: rst_n = 0, then release with en = 1, up_dn = 1 and WIDTH = 4 -> out SHALL be 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000 with wrap = 1 for one cycle.
REQ-031 Down-count scenario: 20 down steps from 0 -> first out SHALL be 1000 with bin = 15 and wrap = 1, and Hamming distance SHALL be 1 on every step.
REQ-032 Load scenario: load = 1 with load_val = 9 and en = 1 on the same edge -> bin SHALL be 9 and out SHALL be 1101; the next up step SHALL give out = 1111.
REQ-033 Hold scenario: en = 0 for 5 cycles -> out and bin SHALL be unchanged and wrap SHALL be 0.
REQ-034 Mid-cycle reset scenario: rst_n asserted asynchronously between edges at count 7 -> out SHALL be 0000 immediately and stay there until release.
REQ-035 Random scenario: random en, up_dn and load for 1000 cycles against a reference model -> bin SHALL match the model and out SHALL equal bin ^ (bin >> 1) every cycle.
